data_mem_sized: RTL
===================

// Module: data_mem_sized
// PURPOSE
// - Byte-addressable data memory for the RV32I load/store path with full RV32I access sizes
//   (LB/LH/LW/LBU/LHU, SB/SH/SW) and a valid/ready request, valid-pulse response handshake.
// - Adds a programmable access latency and error reporting for misaligned, out-of-range and illegal accesses.
// - Sits between the core's MEM stage and its word storage; one outstanding request at a time.
// PARAMETERS
// - DEPTH_WORDS  256  number of 32-bit words; power of two, >= 4
// - LATENCY      0    extra wait cycles per access, 0..7
// PORTS
// - clk        in   1   clock; all state updates on rising edge
// - rst        in   1   asynchronous, active-high reset
// - req_valid  in   1   request present
// - req_ready  out  1   block can accept a request this cycle
// - req_we     in   1   1 = store, 0 = load
// - req_funct3 in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - req_addr   in   32  byte address
// - req_wdata  in   32  store data; B uses [7:0], H uses [15:0]
// - rsp_valid  out  1   one-cycle response pulse
// - rsp_rdata  out  32  load data, sign/zero extended; 0 for stores and errors
// - rsp_err    out  1   access faulted; valid only with rsp_valid
// BEHAVIOUR
// - Reset: state IDLE (or CLEAR, see CONFIGURATION); rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
// - Reset asserted mid-access aborts it: no response issued and any pending write is dropped.
// - FSM states:
//   - IDLE: req_ready=1; on req_valid latch we/funct3/addr/wdata.
//     Go to WAIT if LATENCY>0, else to RESP.
//   - WAIT: req_ready=0; count LATENCY cycles, then go to RESP.
//   - RESP: rsp_valid=1 for exactly one cycle; req_ready=1.
//     A request accepted here is latched and handled as from IDLE; otherwise go to IDLE.
// - Latency: request accepted at edge N -> rsp_valid high in the cycle after edge N+1+LATENCY.
//   Sustained throughput is one access per LATENCY+1 cycles.
// - Store commit: the write lands on the edge that enters RESP. A load accepted in that RESP cycle sees it.
// - Byte lanes (little-endian): B lane=addr[1:0]; H lanes {addr[1],0},{addr[1],1}; W all four lanes.
//   A store writes only its lanes; other bytes of the word are unchanged.
// - Load extraction from word addr[31:2]:
//   - B sign-extends bit 7 of the lane; BU zero-extends.
//   - H sign-extends bit 15; HU zero-extends.
// - Errors (rsp_err=1, no write, rsp_rdata=0):
//   - misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
//   - out of range: addr[31:2] >= DEPTH_WORDS.
//   - illegal funct3: load 011/110/111; store anything but 000/001/010.
// - req_* inputs are sampled only on accept; changes while not ready are ignored.
// - Memory contents persist across reset unless DMEM_INIT_CLEAR_EN is defined.
// CONFIGURATION
// - DMEM_INIT_CLEAR_EN defined:
//   - Reset enters CLEAR; one word is zeroed per cycle, index 0..DEPTH_WORDS-1, req_ready=0.
//   - Then go to IDLE, so the first request is accepted DEPTH_WORDS cycles after reset release.
//   - Reset during CLEAR restarts the sweep at index 0.
// - DMEM_INIT_CLEAR_EN undefined: no CLEAR state; IDLE is entered directly from reset and contents are undefined.
// STRUCTURE
// - Package dmem_pkg holds:
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
//   - state typedef dmem_state_t {IDLE, WAIT, RESP, CLEAR}.
//   - lane-mask helper constants.
// - Sub-module dmem_load_align: combinational word + addr[1:0] + funct3 -> extended rsp data.
// - Top holds the FSM, wait counter, clear index, error decode and word array with byte-enable write.
// TESTING
// - LATENCY=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 1 cycle after each accept.
// - After that word: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
// - SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; SH 0x1234 @0x12, then LW @0x10 -> 0x123455EF.
// - Errors: LW @0x02, LH @0x01, SW @(DEPTH_WORDS*4) and funct3=011 load all give rsp_err=1, rsp_rdata=0, memory unchanged.
// - LATENCY=3 with req_valid held high: rsp_valid 4 cycles after each accept; req_ready=0 in WAIT; back-to-back accept in RESP.
// - Reset asserted during WAIT of a SW: no rsp_valid, word unchanged. With DMEM_INIT_CLEAR_EN, req_ready=0 for DEPTH_WORDS cycles, then LW @0 -> 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized RV32I data memory: funct3 codes, FSM states,
// byte-lane masks and store-data lane replication.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} dmem_state_t;

    localparam logic [3:0] LANES_B = 4'b0001;
    localparam logic [3:0] LANES_H = 4'b0011;
    localparam logic [3:0] LANES_W = 4'b1111;

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b00:   return LANES_B << lo;
            2'b01:   return LANES_H << {lo[1], 1'b0};
            default: return LANES_W;
        endcase
    endfunction

    // Replicate narrow store data into every lane so the byte enables pick the right one.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data extraction: selects the addressed byte/halfword of a word and
// sign- or zero-extends it according to funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*lo +: 8];
        half_sel = lo[1] ? word[31:16] : word[15:0];
        data     = word;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressable RV32I data memory with valid/ready requests, programmable latency
// and error reporting. Define DMEM_INIT_CLEAR_EN to zero the array after every reset.
module data_mem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state_reg, state_next;
    logic [2:0]  wait_cnt_reg, wait_cnt_next;

    logic        we_reg;
    logic [2:0]  f3_reg;
    logic [31:0] addr_reg, wdata_reg;

    logic        acc_we_reg, acc_err_reg;
    logic [2:0]  acc_f3_reg;
    logic [1:0]  acc_lo_reg;

    logic        rsp_valid_reg, rsp_err_reg;
    logic [31:0] rsp_rdata_reg;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_reg;
    logic [31:0] load_data;

    logic        accept, enter_resp;
    logic        cur_we, cur_err;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata;
    logic        wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

`ifdef DMEM_INIT_CLEAR_EN
    logic [AW-1:0] clear_idx_reg;
    localparam dmem_state_t RESET_STATE = CLEAR;
`else
    localparam dmem_state_t RESET_STATE = IDLE;
`endif

    assign req_ready = (state_reg == IDLE) || (state_reg == RESP);
    assign accept    = req_valid && req_ready;

    // A zero-latency accept performs the access on the same edge, so it uses the live inputs.
    assign cur_we    = (state_reg == WAIT) ? we_reg    : req_we;
    assign cur_f3    = (state_reg == WAIT) ? f3_reg    : req_funct3;
    assign cur_addr  = (state_reg == WAIT) ? addr_reg  : req_addr;
    assign cur_wdata = (state_reg == WAIT) ? wdata_reg : req_wdata;

    always_comb begin
        logic illegal, misaligned, out_of_range;
        illegal      = cur_we ? !(cur_f3 inside {F3_B, F3_H, F3_W})
                              : !(cur_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                       ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        out_of_range = cur_addr[31:2] >= 30'(DEPTH_WORDS);
        cur_err      = illegal || misaligned || out_of_range;
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        enter_resp    = 1'b0;
        case (state_reg)
            IDLE, RESP: begin
                state_next = IDLE;
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = 3'(LATENCY - 1);
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 3'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end
            end
            CLEAR: begin
`ifdef DMEM_INIT_CLEAR_EN
                if (clear_idx_reg == AW'(DEPTH_WORDS - 1))
                    state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RESET_STATE;
            wait_cnt_reg  <= 3'd0;
            we_reg        <= 1'b0;
            f3_reg        <= 3'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            acc_we_reg    <= 1'b0;
            acc_err_reg   <= 1'b0;
            acc_f3_reg    <= 3'd0;
            acc_lo_reg    <= 2'd0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                f3_reg    <= req_funct3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (enter_resp) begin
                acc_we_reg  <= cur_we;
                acc_err_reg <= cur_err;
                acc_f3_reg  <= cur_f3;
                acc_lo_reg  <= cur_addr[1:0];
            end
            rsp_valid_reg <= (state_reg == RESP);
            rsp_err_reg   <= (state_reg == RESP) && acc_err_reg;
            rsp_rdata_reg <= ((state_reg == RESP) && !acc_we_reg && !acc_err_reg) ? load_data : 32'd0;
        end
    end

`ifdef DMEM_INIT_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clear_idx_reg <= '0;
        else if (state_reg == CLEAR)
            clear_idx_reg <= clear_idx_reg + 1'b1;
    end

    assign wr_en   = !rst && ((enter_resp && cur_we && !cur_err) || (state_reg == CLEAR));
    assign wr_idx  = (state_reg == CLEAR) ? clear_idx_reg : cur_addr[AW+1:2];
    assign wr_be   = (state_reg == CLEAR) ? LANES_W : lane_mask(cur_f3, cur_addr[1:0]);
    assign wr_data = (state_reg == CLEAR) ? 32'd0 : store_lanes(cur_f3, cur_wdata);
`else
    assign wr_en   = !rst && enter_resp && cur_we && !cur_err;
    assign wr_idx  = cur_addr[AW+1:2];
    assign wr_be   = lane_mask(cur_f3, cur_addr[1:0]);
    assign wr_data = store_lanes(cur_f3, cur_wdata);
`endif

    // Word array: registered read on the access edge, byte-enable write.
    always_ff @(posedge clk) begin
        if (enter_resp)
            rd_word_reg <= mem[cur_addr[AW+1:2]];
        for (int b = 0; b < 4; b++)
            if (wr_en && wr_be[b])
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end

    dmem_load_align u_align (
        .word   (rd_word_reg),
        .lo     (acc_lo_reg),
        .funct3 (acc_f3_reg),
        .data   (load_data)
    );

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule
